// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: opcode encoding, default operand width and opcode legality check.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_SUB = 3'b001,
        OP_LT  = 3'b011
    } alu_op_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_LT);
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Storage and pointer logic for the issue queue; head visible one cycle after a push into empty.
// A push is refused when full and a pop is ignored when empty, so nothing is overwritten.
module alu_issue_fifo #(
    parameter  int W     = 35,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head_dat  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage is deliberately left out of reset; the head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count resolves full vs empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: drops illegal opcodes (one-cycle pulse + saturating count), queues the rest in order.
// One cycle from push to head visibility; in_ready depends only on occupancy, never on out_ready.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_opcode,
    output logic [CW-1:0]    count,
    output logic             illegal_op,
    output logic [7:0]       illegal_cnt
);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a;
    } entry_t;

    entry_t     w_in_entry;
    entry_t     w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_legal;
    logic       w_store;
    logic       w_pop;
    logic       r_illegal_op;
    logic [7:0] r_illegal_cnt;

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign w_accept   = in_valid && in_ready;
    assign w_legal    = is_legal_op(in_opcode);
    // Illegal requests still complete the handshake; they simply never reach storage.
    assign w_store    = w_accept && w_legal;
    assign w_pop      = out_valid && out_ready;
    assign w_in_entry = '{op: in_opcode, b: in_b, a: in_a};

    alu_issue_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_store),
        .push_dat (w_in_entry),
        .pop      (w_pop),
        .head_dat (w_head),
        .count    (count),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign out_a      = w_head.a;
    assign out_b      = w_head.b;
    assign out_opcode = w_head.op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_op  <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal_op <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_illegal_cnt != 8'hFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    assign illegal_op  = r_illegal_op;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: fill, drain, simultaneous push/pop, illegal filtering, wrap, async reset.
module tb_alu_issue_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_opcode;
    logic [2:0]  count;
    logic        illegal_op;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_queue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_opcode   (in_opcode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_opcode  (out_opcode),
        .count       (count),
        .illegal_op  (illegal_op),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_opcode = 3'b000;
        out_ready = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst_illegal_op", 64'(illegal_op), 64'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;

        // Fill: four legal pushes with the ALU stalled.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_a      = 32'(100 + i);
            in_b      = 32'(200 + i);
            in_opcode = (i % 2 == 0) ? 3'b001 : 3'b011;
            tick();
            if (i == 0) begin
                chk("fill_first_visible", 64'(out_valid), 64'd1);
                chk("fill_first_a", 64'(out_a), 64'd100);
            end
        end
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        in_a      = 32'd999;
        in_opcode = 3'b001;
        tick();
        in_valid = 1'b0;
        chk("fill_5th_count", 64'(count), 64'd4);
        chk("fill_hold_a", 64'(out_a), 64'd100);
        chk("fill_hold_op", 64'(out_opcode), 64'd1);

        // Drain in push order.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_a", 64'(out_a), 64'(100 + i));
            chk("drain_b", 64'(out_b), 64'(200 + i));
            chk("drain_op", 64'(out_opcode), (i % 2 == 0) ? 64'd1 : 64'd3);
            tick();
        end
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Simultaneous push and pop at count 2.
        in_valid  = 1'b1;
        in_opcode = 3'b011;
        in_a      = 32'd10;
        tick();
        in_a = 32'd11;
        tick();
        chk("sim_pre_count", 64'(count), 64'd2);
        in_a      = 32'd12;
        out_ready = 1'b1;
        chk("sim_head0", 64'(out_a), 64'd10);
        tick();
        in_valid = 1'b0;
        chk("sim_count", 64'(count), 64'd2);
        chk("sim_head1", 64'(out_a), 64'd11);
        tick();
        chk("sim_head2", 64'(out_a), 64'd12);
        chk("sim_count_after", 64'(count), 64'd1);
        tick();
        chk("sim_empty", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Illegal opcode: accepted, dropped, one-cycle pulse.
        in_valid  = 1'b1;
        in_opcode = 3'b111;
        in_a      = 32'd55;
        tick();
        in_valid = 1'b0;
        chk("ill_pulse", 64'(illegal_op), 64'd1);
        chk("ill_count", 64'(count), 64'd0);
        chk("ill_out_valid", 64'(out_valid), 64'd0);
        chk("ill_cnt1", 64'(illegal_cnt), 64'd1);
        tick();
        chk("ill_pulse_end", 64'(illegal_op), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 299; i++) begin
            case (i % 6)
                0:       in_opcode = 3'b000;
                1:       in_opcode = 3'b010;
                2:       in_opcode = 3'b100;
                3:       in_opcode = 3'b101;
                4:       in_opcode = 3'b110;
                default: in_opcode = 3'b111;
            endcase
            tick();
            if (i == 253) begin
                chk("ill_cnt255", 64'(illegal_cnt), 64'd255);
            end
        end
        in_valid = 1'b0;
        chk("ill_cnt_sat", 64'(illegal_cnt), 64'd255);
        chk("ill_sat_count", 64'(count), 64'd0);

        // Interleaved push/pop across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_opcode = 3'b001;
            in_a      = 32'(i);
            out_ready = 1'b0;
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("wrap_a", 64'(out_a), 64'(i));
            tick();
            out_ready = 1'b0;
        end
        chk("wrap_count", 64'(count), 64'd0);

        // Async reset mid-operation at count 3.
        in_valid  = 1'b1;
        in_opcode = 3'b011;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'(40 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("rst_pre_count", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_opcode = 3'b001;
        in_a      = 32'd77;
        tick();
        in_valid = 1'b0;
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_a", 64'(out_a), 64'd77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  queue can accept a request this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_opcode  input  3  ALU opcode.
REQ-010 out_valid  output  1  head entry presented to ALU.
REQ-011 out_ready  input  1  ALU stage consumes head this cycle.
REQ-012 out_a, out_b  output  WIDTH each  head operands, driven to the ALU A/B inputs.
REQ-013 out_opcode  output  3  head opcode.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 illegal_op  output  1  one-cycle pulse: illegal opcode was dropped.
REQ-016 illegal_cnt  output  8  saturating count of dropped requests.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready is 1 when count < DEPTH; it does not depend on out_ready (no full-bypass).
REQ-019 out_valid is 1 when count != 0; out_a, out_b and out_opcode show the head entry and hold stable while out_valid && !out_ready.
REQ-020 Latency: a request pushed into an empty queue is visible on out_* in the next cycle; there is no same-cycle passthrough.
REQ-021 Legal opcodes are 3'b001 (SUB) and 3'b011 (LT); all others are illegal.
REQ-022 A handshaken request with an illegal opcode is accepted, not stored, and count is unchanged by it.
REQ-023 illegal_op is 1 in the cycle after an illegal request is accepted.
REQ-024 illegal_cnt increments on each illegal request and saturates at 255.
REQ-025 A simultaneous push and pop with count between 1 and DEPTH-1 leaves count unchanged and preserves FIFO order.
REQ-026 A simultaneous push and pop with count 0 is impossible, because out_valid is 0.
REQ-027 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count distinguishes full from empty.
REQ-028 Entries are strictly FIFO ordered; no reordering and no overwrite of occupied entries.
REQ-029 With in_valid low, in_* values are ignored; with out_ready low, nothing is popped.

Reset
REQ-030 On rst assertion, count, pointers, illegal_op and illegal_cnt go to 0 immediately, without waiting for clk.
REQ-031 During reset, out_valid is 0 and in_ready is 1; in-flight entries are discarded.
REQ-032 Storage array contents are not reset; out_a, out_b and out_opcode are don't-care while out_valid is 0.
REQ-033 Reset deassertion is synchronised externally; the first push after reset is taken on the first rising edge with rst low.

Structure
REQ-034 Shared package alu_pkg holds the opcode enum (OP_SUB=3'b001, OP_LT=3'b011), the default WIDTH constant, and an is_legal_op function.
REQ-035 The storage and pointer logic is one sub-module, alu_issue_fifo, parameterised by WIDTH+3 and DEPTH.
REQ-036 Opcode filtering, the illegal pulse and the illegal counter are implemented in alu_issue_queue itself.

Verification
REQ-037 Fill test: reset, push 4 legal requests with out_ready=0 -> count=4, in_ready=0; a 5th push attempt is not accepted; out_a holds the first A.
REQ-038 Drain test: from full, hold out_ready=1 -> 4 pops in push order; out_valid=0 afterwards; count=0.
REQ-039 Simultaneous test: at count=2, push and pop in the same cycle -> count stays 2 and the output order matches the input order.
REQ-040 Illegal test: push opcode 3'b111 -> illegal_op=1 for exactly one cycle, count unchanged, illegal_cnt=1; 300 illegal pushes -> illegal_cnt=255.
REQ-041 Wrap test: 10 interleaved push/pop cycles with A=0..9 -> outputs 0..9 in order across pointer wrap.
REQ-042 Reset test: assert rst mid-operation at count=3, asynchronously to clk -> count=0, out_valid=0, illegal_cnt=0 before the next edge.
